// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg : shared fetch-stage types, widths and default constants     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cpu_pkg;

  localparam int          c_xlen        = 16;
  localparam logic [15:0] c_reset_pc    = 16'h0000;
  localparam logic [15:0] c_nop_instr   = 16'h0000;
  localparam logic [3:0]  c_halt_opcode = 4'hF;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit_if : control, imem and IF/ID signals of the fetch stage   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface fetch_unit_if;
  import cpu_pkg::*;

  logic              Stall;
  logic              Redirect;
  logic [c_xlen-1:0] RedirectAdresa;
  logic [c_xlen-1:0] Instruksioni;
  logic [c_xlen-1:0] PCAdresa;
  logic [c_xlen-1:0] IF_ID_Instr;
  logic [c_xlen-1:0] IF_ID_PCPlus2;
  logic              IF_ID_Valid;
  logic              Halted;
  logic              FaultOOR;
  logic              AlignErr;

  modport master (
    input  Stall, Redirect, RedirectAdresa, Instruksioni,
    output PCAdresa, IF_ID_Instr, IF_ID_PCPlus2, IF_ID_Valid,
           Halted, FaultOOR, AlignErr
  );

  modport slave (
    output Stall, Redirect, RedirectAdresa, Instruksioni,
    input  PCAdresa, IF_ID_Instr, IF_ID_PCPlus2, IF_ID_Valid,
           Halted, FaultOOR, AlignErr
  );

endinterface
`default_nettype wire

// File: rtl/fetch_unit_pc_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_reg : program counter with redirect/stall/increment/hold mux      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pc_reg import cpu_pkg::*; #(
  parameter logic [c_xlen-1:0] RESET_PC = c_reset_pc
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_redirect,
  input  logic [c_xlen-1:0] i_redirect_addr,
  input  logic              i_stall,
  input  logic              i_advance,
  output logic [c_xlen-1:0] o_pc
);

  logic [c_xlen-1:0] r_pc;
  logic [c_xlen-1:0] w_pc_next;

  // Redirect overrides a stall; bit 0 is forced low so fetches stay word aligned.
  always_comb begin
    w_pc_next = r_pc;
    if (i_redirect) begin
      w_pc_next = {i_redirect_addr[c_xlen-1:1], 1'b0};
    end else if (!i_stall && i_advance) begin
      w_pc_next = r_pc + c_xlen'(2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= {RESET_PC[c_xlen-1:1], 1'b0};
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign o_pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit : PC ownership, IF/ID register, halt and fault control    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fetch_unit import cpu_pkg::*; #(
  parameter logic [c_xlen-1:0] RESET_PC    = c_reset_pc,
  parameter int                IMEM_BYTES  = 128,
  parameter logic [3:0]        HALT_OPCODE = c_halt_opcode,
  parameter logic [c_xlen-1:0] NOP_INSTR   = c_nop_instr
) (
  input  logic         Clock,
  input  logic         Reset,
  fetch_unit_if.master bus
);

  localparam int c_last_pc = IMEM_BYTES - 2;

  fetch_state_e      r_state, w_state_next;
  logic [c_xlen-1:0] r_instr, w_instr_next;
  logic [c_xlen-1:0] r_pcplus2, w_pcplus2_next;
  logic              r_valid, w_valid_next;
  logic              r_fault, w_fault_next;
  logic              r_align, w_align_next;
  logic [c_xlen-1:0] w_pc;
  logic              w_redirect, w_advance, w_oor, w_halt;

  assign w_oor      = int'(w_pc) > c_last_pc;
  assign w_halt     = bus.Instruksioni[c_xlen-1 -: 4] == HALT_OPCODE;
  assign w_redirect = (r_state != BOOT) && bus.Redirect;
  // A halt word is captured but the PC stays on it.
  assign w_advance  = (r_state == RUN) && !w_oor && !w_halt;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk             (Clock),
    .rst_n           (Reset),
    .i_redirect      (w_redirect),
    .i_redirect_addr (bus.RedirectAdresa),
    .i_stall         (bus.Stall),
    .i_advance       (w_advance),
    .o_pc            (w_pc)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state   <= BOOT;
      r_instr   <= NOP_INSTR;
      r_pcplus2 <= '0;
      r_valid   <= 1'b0;
      r_fault   <= 1'b0;
      r_align   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_instr   <= w_instr_next;
      r_pcplus2 <= w_pcplus2_next;
      r_valid   <= w_valid_next;
      r_fault   <= w_fault_next;
      r_align   <= w_align_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_instr_next   = r_instr;
    w_pcplus2_next = r_pcplus2;
    w_valid_next   = r_valid;
    w_fault_next   = r_fault;
    w_align_next   = 1'b0;
    case (r_state)
      BOOT: w_state_next = RUN;
      RUN, HALTED: begin
        if (bus.Redirect) begin
          w_state_next = RUN;
          w_instr_next = NOP_INSTR;
          w_valid_next = 1'b0;
          w_align_next = bus.RedirectAdresa[0];
        end else if (!bus.Stall) begin
          if (r_state == HALTED) begin
            w_instr_next = NOP_INSTR;
            w_valid_next = 1'b0;
          end else if (w_oor) begin
            w_fault_next = 1'b1;
            w_valid_next = 1'b0;
            w_state_next = HALTED;
          end else begin
            w_instr_next   = bus.Instruksioni;
            w_pcplus2_next = w_pc + c_xlen'(2);
            w_valid_next   = 1'b1;
            if (w_halt) begin
              w_state_next = HALTED;
            end
          end
        end
      end
      default: w_state_next = BOOT;
    endcase
  end

  assign bus.PCAdresa      = w_pc;
  assign bus.IF_ID_Instr   = r_instr;
  assign bus.IF_ID_PCPlus2 = r_pcplus2;
  assign bus.IF_ID_Valid   = r_valid;
  assign bus.Halted        = (r_state == HALTED);
  assign bus.FaultOOR      = r_fault;
  assign bus.AlignErr      = r_align;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_unit : directed + random stimulus against a reference model |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam int IMEM_BYTES = 128;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(
    .RESET_PC    (16'h0000),
    .IMEM_BYTES  (IMEM_BYTES),
    .HALT_OPCODE (4'hF),
    .NOP_INSTR   (16'h0000)
  ) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  // Byte-addressed big-endian instruction memory with combinational read.
  logic [7:0] mem [0:255];
  always_comb bus.Instruksioni = {mem[bus.PCAdresa[7:0]], mem[8'(bus.PCAdresa[7:0] + 8'd1)]};

  int checks = 0;
  int errors = 0;

  // Reference model of the fetch stage as seen from its outputs.
  logic [15:0] m_pc, m_instr, m_p2;
  logic        m_valid, m_halted, m_fault, m_align, m_boot;

  task automatic set_word(input int a, input logic [15:0] w);
    mem[a]     = w[15:8];
    mem[a + 1] = w[7:0];
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = 16'h0000; m_p2 = 16'h0000;
    m_valid = 1'b0; m_halted = 1'b0; m_fault = 1'b0; m_align = 1'b0; m_boot = 1'b1;
  endtask

  task automatic model_edge(input logic s, input logic r, input logic [15:0] a);
    logic [15:0] w;
    w = {mem[m_pc[7:0]], mem[8'(m_pc[7:0] + 8'd1)]};
    m_align = 1'b0;
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (r) begin
      m_pc = a & 16'hFFFE;
      m_instr = 16'h0000; m_valid = 1'b0; m_align = a[0]; m_halted = 1'b0;
    end else if (!s) begin
      if (m_halted) begin
        m_valid = 1'b0; m_instr = 16'h0000;
      end else if (int'(m_pc) > IMEM_BYTES - 2) begin
        m_fault = 1'b1; m_valid = 1'b0; m_halted = 1'b1;
      end else begin
        m_instr = w; m_p2 = 16'(m_pc + 16'd2); m_valid = 1'b1;
        if (w[15:12] == 4'hF) m_halted = 1'b1;
        else m_pc = 16'(m_pc + 16'd2);
      end
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("pc",     bus.PCAdresa,            m_pc);
    check("instr",  bus.IF_ID_Instr,         m_instr);
    check("pcplus2", bus.IF_ID_PCPlus2,      m_p2);
    check("valid",  16'(bus.IF_ID_Valid),    16'(m_valid));
    check("halted", 16'(bus.Halted),         16'(m_halted));
    check("fault",  16'(bus.FaultOOR),       16'(m_fault));
    check("align",  16'(bus.AlignErr),       16'(m_align));
  endtask

  task automatic step(input logic s, input logic r, input logic [15:0] a);
    bus.Stall = s; bus.Redirect = r; bus.RedirectAdresa = a;
    @(posedge clk);
    model_edge(s, r, a);
    #1 compare_all();
  endtask

  initial begin
    logic [15:0] w;
    rst_n = 1'b1;
    bus.Stall = 1'b0; bus.Redirect = 1'b0; bus.RedirectAdresa = 16'h0000;
    for (int i = 0; i < 256; i += 2) begin
      w = 16'($urandom);
      w[15:12] = 4'($urandom_range(0, 14));
      set_word(i, w);
    end
    set_word(0, 16'h1234); set_word(2, 16'h5678);
    set_word(4, 16'h9ABC); set_word(6, 16'hF000);
    set_word(32, 16'h1111);

    #1 rst_n = 1'b0;
    #2 model_reset();
    compare_all();
    @(negedge clk) rst_n = 1'b1;

    // Boot cycle, then two sequential fetches.
    step(0, 0, 0);  check("boot_valid", 16'(bus.IF_ID_Valid), 16'h0000);
    step(0, 0, 0);  check("f0_instr", bus.IF_ID_Instr, 16'h1234);
                    check("f0_pc", bus.PCAdresa, 16'h0002);
    step(0, 0, 0);  check("f1_instr", bus.IF_ID_Instr, 16'h5678);
                    check("f1_p2", bus.IF_ID_PCPlus2, 16'h0004);

    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0); check("stall_pc", bus.PCAdresa, 16'h0004);
    end

    // Redirect to an odd target while stalled.
    step(1, 1, 16'h0021); check("redir_pc", bus.PCAdresa, 16'h0020);
                          check("redir_align", 16'(bus.AlignErr), 16'h0001);
    step(0, 0, 0);        check("align_pulse", 16'(bus.AlignErr), 16'h0000);
                          check("redir_instr", bus.IF_ID_Instr, 16'h1111);

    // Halt word at address 6.
    step(0, 1, 16'h0004);
    step(0, 0, 0);
    step(0, 0, 0);  check("halt_instr", bus.IF_ID_Instr, 16'hF000);
                    check("halt_p2", bus.IF_ID_PCPlus2, 16'h0008);
                    check("halt_pc", bus.PCAdresa, 16'h0006);
                    check("halt_flag", 16'(bus.Halted), 16'h0001);
    step(0, 0, 0);  check("halt_bubble", 16'(bus.IF_ID_Valid), 16'h0000);
    step(0, 1, 16'h0000); check("unhalt", 16'(bus.Halted), 16'h0000);
    step(0, 0, 0);  check("restart", bus.IF_ID_Instr, 16'h1234);

    // Straight-line run off the end of memory.
    step(0, 1, 16'h0070);
    for (int i = 0; i < 8; i++) step(0, 0, 0);
    check("last_p2", bus.IF_ID_PCPlus2, 16'h0080);
    step(0, 0, 0);  check("oor_fault", 16'(bus.FaultOOR), 16'h0001);
                    check("oor_halt", 16'(bus.Halted), 16'h0001);
    step(0, 1, 16'h0000); check("fault_sticky", 16'(bus.FaultOOR), 16'h0001);
    step(0, 0, 0);

    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    #1 model_reset();
    compare_all();
    check("async_pc", bus.PCAdresa, 16'h0000);
    @(negedge clk) rst_n = 1'b1;

    set_word(64, 16'hF123); set_word(90, 16'hFABC);
    for (int i = 0; i < 500; i++) begin
      if (i == 250) begin
        @(negedge clk) rst_n = 1'b0;
        #1 model_reset();
        compare_all();
        @(negedge clk) rst_n = 1'b1;
      end
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
           16'($urandom_range(0, 132)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the byte-addressed instruction memory. It owns the program counter and drives PCAdresa. It captures the returned 16-bit big-endian instruction word, together with PC+2, into an IF/ID pipeline register for decode. It handles stall, redirect (branch/jump flush), halt detection and out-of-range fetch faults.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
IMEM_BYTES, 128, instruction memory size in bytes; last legal fetch address is IMEM_BYTES-2.
HALT_OPCODE, 4'hF, value of Instruksioni[15:12] that marks a halt instruction.
NOP_INSTR, 16'h0000, word loaded into IF/ID on reset, flush or bubble.

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  asynchronous, active-low reset
Stall  in  1  downstream hazard; hold PC and IF/ID
Redirect  in  1  taken branch/jump from later stage; flush and load new PC
RedirectAdresa  in  16  target byte address for Redirect
Instruksioni  in  16  instruction word from instruction memory (combinational read of PCAdresa)
PCAdresa  out  16  current PC to instruction memory
IF_ID_Instr  out  16  captured instruction
IF_ID_PCPlus2  out  16  PC of captured instruction + 2
IF_ID_Valid  out  1  IF/ID holds a real instruction
Halted  out  1  high while in HALTED
FaultOOR  out  1  sticky; set when PC exceeds IMEM_BYTES-2
AlignErr  out  1  one-cycle pulse when RedirectAdresa[0]=1

Behaviour:
- Reset (Reset=0, asynchronous): PC=RESET_PC, IF_ID_Instr=NOP_INSTR, IF_ID_PCPlus2=0, IF_ID_Valid=0, state=BOOT, Halted=0, FaultOOR=0, AlignErr=0.
- PCAdresa = PC (registered, no combinational path from inputs).
- State machine:
  - BOOT: one cycle; no capture, PC held, Valid=0. Next state is RUN unconditionally.
  - RUN: normal fetch.
  - HALTED: PC held.
- Per-edge priority in RUN: Redirect > Stall > FaultOOR check > halt detect > normal.
  - Redirect=1 (also during Stall): PC <= {RedirectAdresa[15:1],1'b0}; IF_ID_Instr<=NOP_INSTR; Valid<=0. AlignErr<=RedirectAdresa[0] for one cycle, otherwise 0.
  - Stall=1: PC and all IF/ID outputs hold.
  - PC > IMEM_BYTES-2: FaultOOR<=1 (sticky until reset); Valid<=0; state->HALTED; no capture.
  - Instruksioni[15:12]==HALT_OPCODE: capture as a normal fetch (Valid=1), PC held (not advanced), state->HALTED.
  - Normal: IF_ID_Instr<=Instruksioni; IF_ID_PCPlus2<=PC+2; Valid<=1; PC<=PC+2.
- HALTED:
  - Stall=1: IF/ID holds, so the halt instruction is not lost.
  - Stall=0: Valid<=0 (bubble), Instr<=NOP_INSTR.
  - Redirect=1: apply the redirect and return to RUN (an older in-flight branch cancels the halt). FaultOOR stays set.
- Arithmetic: PC+2 is modulo 2^16; 16'hFFFE+2=16'h0000 (the OOR check fires first when IMEM_BYTES<65536). PC[0] is always 0.
- Latency: the instruction at PC appears on IF_ID_* one edge after PC is presented.
- Halted = (state==HALTED).

Decomposition:
- Shared package cpu_pkg: fetch state enum (BOOT, RUN, HALTED), NOP_INSTR, HALT_OPCODE, RESET_PC defaults, instruction/address width constant (16).
- One sub-module, pc_reg: PC register plus next-PC priority mux (redirect/stall/increment/hold), with the alignment mask.
- The FSM and IF/ID register live in fetch_unit.

Test Plan:
- Reset release, memory holding 16'h1234 at 0 and 16'h5678 at 2: edge 1 is BOOT (Valid=0); edge 2 gives Instr=1234, PCPlus2=0002, PCAdresa=0002; edge 3 gives Instr=5678, PCPlus2=0004.
- Stall=1 for 3 cycles mid-stream: PCAdresa and IF_ID_* are unchanged for all three; fetch resumes at the held PC on release.
- Redirect=1, RedirectAdresa=16'h0021, with Stall=1 simultaneously: next PCAdresa=0020, Valid=0, Instr=0000, AlignErr pulses for exactly one cycle.
- Memory word F000 at address 6: it is captured with Valid=1 and PCPlus2=0008; Halted=1 and PCAdresa stays 0006. The following cycle Valid=0. A later Redirect to 0000 clears Halted and fetch restarts.
- IMEM_BYTES=128, straight-line code with no halt: after the capture at PC=126, PC=128 sets FaultOOR=1 and Halted=1; FaultOOR stays set through a subsequent Redirect.
- Reset asserted asynchronously mid-stream (between edges): all outputs go immediately to their reset values, and PCAdresa=RESET_PC.
